// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline-register family: mode constants and a
// width helper for pointers and occupancy counters.
package pipeline_pkg;

  localparam int BYPASS_OFF = 0;
  localparam int BYPASS_ON  = 1;

  // Bits needed to index n distinct values, never less than 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipeline_fifo_mem.sv
// Depth x Width token storage: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module pipeline_fifo_mem #(
  parameter int Width     = 8,
  parameter int Depth     = 2,
  parameter int AddrWidth = 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_fifo.sv
// Parametrised elastic buffer on the valid/backpressure channel, registered or
// fall-through. PIPELINE_FIFO_STATUS_EN adds almost_full and simulation checks.
module pipeline_fifo
  import pipeline_pkg::*;
#(
  parameter int Width           = 8,
  parameter int Depth           = 2,
  parameter int Bypass          = BYPASS_OFF,
  parameter int AlmostFullLevel = Depth - 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [Width-1:0]                d,
  input  logic                            d_valid,
  output logic                            d_bp,
  output logic [Width-1:0]                q,
  output logic                            q_valid,
  input  logic                            q_bp,
  output logic [clog2_min1(Depth+1)-1:0]  count
`ifdef PIPELINE_FIFO_STATUS_EN
  , output logic                          almost_full
`endif
);

  localparam int CW = clog2_min1(Depth + 1);
  localparam int PW = clog2_min1(Depth);
  localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
  localparam logic [PW-1:0] LAST_C  = PW'(Depth - 1);

  if (Width < 1 || Depth < 1 || AlmostFullLevel < 0) begin : g_bad_params
    $error("pipeline_fifo: illegal parameter set");
  end

  logic [CW-1:0]    count_reg, count_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [Width-1:0] mem_rdata;
  logic             empty, accept, emit, pass_through, wr_en, rd_en;

  pipeline_fifo_mem #(
    .Width     (Width),
    .Depth     (Depth),
    .AddrWidth (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (d),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign empty = (count_reg == '0);
  // Backpressure comes only from the registered count, so q_bp never reaches d_bp.
  assign d_bp  = (count_reg == DEPTH_C);
  assign count = count_reg;

  if (Bypass == BYPASS_ON) begin : g_fall_through
    assign q_valid = empty ? (d_valid && resetn) : 1'b1;
    assign q       = empty ? d : mem_rdata;
  end else begin : g_registered
    assign q_valid = !empty;
    assign q       = mem_rdata;
  end

  assign accept       = d_valid && !d_bp;
  assign emit         = q_valid && !q_bp;
  assign pass_through = (Bypass == BYPASS_ON) && empty && accept && emit;
  assign wr_en        = accept && !pass_through;
  assign rd_en        = emit && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    // Explicit wrap so non-power-of-two depths work.
    if (wr_en) wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
    if (rd_en) rd_ptr_next = (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

`ifdef PIPELINE_FIFO_STATUS_EN
  logic             almost_full_reg;
  logic             held_reg;
  logic [Width-1:0] d_hold_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      almost_full_reg <= 1'b0;
      held_reg        <= 1'b0;
    end else begin
      almost_full_reg <= (int'(count_next) >= AlmostFullLevel);
      held_reg        <= d_valid && d_bp;
    end
  end

  always_ff @(posedge clk) begin
    d_hold_reg <= d;
  end

  assign almost_full = almost_full_reg;

  // A refused token must be re-presented unchanged.
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(held_reg && d_valid && (d != d_hold_reg)));
      assert (count_reg <= DEPTH_C);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fifo.sv
// Bench for pipeline_fifo: three instances (Depth 3 registered, Depth 2
// registered, Depth 2 fall-through) checked every cycle against a queue model.
module tb_pipeline_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] d       [3];
  logic       d_valid [3];
  logic       d_bp    [3];
  logic [7:0] q       [3];
  logic       q_valid [3];
  logic       q_bp    [3];
  logic [1:0] count   [3];
`ifdef PIPELINE_FIFO_STATUS_EN
  logic       almost_full [3];
`endif

  always #5 clk = ~clk;

  pipeline_fifo #(.Width(8), .Depth(3), .Bypass(0)) u0 (
    .clk(clk), .resetn(resetn), .d(d[0]), .d_valid(d_valid[0]), .d_bp(d_bp[0]),
    .q(q[0]), .q_valid(q_valid[0]), .q_bp(q_bp[0]), .count(count[0])
`ifdef PIPELINE_FIFO_STATUS_EN
    , .almost_full(almost_full[0])
`endif
  );

  pipeline_fifo #(.Width(8), .Depth(2), .Bypass(0)) u1 (
    .clk(clk), .resetn(resetn), .d(d[1]), .d_valid(d_valid[1]), .d_bp(d_bp[1]),
    .q(q[1]), .q_valid(q_valid[1]), .q_bp(q_bp[1]), .count(count[1])
`ifdef PIPELINE_FIFO_STATUS_EN
    , .almost_full(almost_full[1])
`endif
  );

  pipeline_fifo #(.Width(8), .Depth(2), .Bypass(1)) u2 (
    .clk(clk), .resetn(resetn), .d(d[2]), .d_valid(d_valid[2]), .d_bp(d_bp[2]),
    .q(q[2]), .q_valid(q_valid[2]), .q_bp(q_bp[2]), .count(count[2])
`ifdef PIPELINE_FIFO_STATUS_EN
    , .almost_full(almost_full[2])
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
  endtask

  // Reference model: contents of each buffer as a plain queue.
  logic [7:0] mq [3][$];
  bit         af_exp [3];

  function automatic int dep_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic bit byp_of(input int i);
    return (i == 2);
  endfunction

  function automatic bit exp_qv(input int i);
    if (!resetn) return 1'b0;
    return (mq[i].size() != 0) || (byp_of(i) && d_valid[i]);
  endfunction

  function automatic logic [7:0] exp_q(input int i);
    return (mq[i].size() != 0) ? mq[i][0] : d[i];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        af_exp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int sz;
        bit acc, emt;
        sz  = mq[i].size();
        acc = d_valid[i] && (sz != dep_of(i));
        emt = exp_qv(i) && !q_bp[i];
        if (!(sz == 0 && emt)) begin
          if (emt) void'(mq[i].pop_front());
          if (acc) mq[i].push_back(d[i]);
        end
        af_exp[i] = (mq[i].size() >= dep_of(i) - 1);
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("q_valid", i, 32'(q_valid[i]), 32'(exp_qv(i)));
      if (exp_qv(i)) chk("q", i, 32'(q[i]), 32'(exp_q(i)));
      chk("count", i, 32'(count[i]), 32'(mq[i].size()));
      chk("d_bp", i, 32'(d_bp[i]), 32'(mq[i].size() == dep_of(i)));
`ifdef PIPELINE_FIFO_STATUS_EN
      chk("almost_full", i, 32'(almost_full[i]), 32'(af_exp[i]));
`endif
    end
  end

  logic [7:0] out0 [$];
  always @(posedge clk) begin
    if (resetn && q_valid[0] && !q_bp[0]) out0.push_back(q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [3];
    bit acc [3];
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'h00; d_valid[i] = 1'b0; q_bp[i] = 1'b0;
    end
    repeat (2) step();
    resetn = 1'b1;

    // Asynchronous reset with tokens held.
    q_bp[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d[0] = 8'h30 + 8'(k); d_valid[0] = 1'b1; step();
    end
    d_valid[0] = 1'b0;
    chk("held_count", 0, 32'(count[0]), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("rst_q_valid", 0, 32'(q_valid[0]), 32'd0);
    chk("rst_count", 0, 32'(count[0]), 32'd0);
    chk("rst_d_bp", 0, 32'(d_bp[0]), 32'd0);
    step();
    resetn = 1'b1; q_bp[0] = 1'b0;
    d[0] = 8'h11; d_valid[0] = 1'b1;
    step();
    d_valid[0] = 1'b0;
    chk("post_rst_q", 0, 32'(q[0]), 32'h11);
    chk("post_rst_qv", 0, 32'(q_valid[0]), 32'd1);
    step();

    // Fill and drain with a held refused token.
    q_bp[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d[0] = 8'hA0 + 8'(k); d_valid[0] = 1'b1; step();
    end
    chk("full_count", 0, 32'(count[0]), 32'd3);
    chk("full_d_bp", 0, 32'(d_bp[0]), 32'd1);
    d[0] = 8'hA3;
    step();
    chk("refused_count", 0, 32'(count[0]), 32'd3);
    q_bp[0] = 1'b0;
    step();
    chk("drain_d_bp", 0, 32'(d_bp[0]), 32'd0);
    chk("drain_count", 0, 32'(count[0]), 32'd2);
    chk("drain_q1", 0, 32'(q[0]), 32'hA1);
    step();
    d_valid[0] = 1'b0;
    chk("drain_q2", 0, 32'(q[0]), 32'hA2);
    step();
    chk("drain_q3", 0, 32'(q[0]), 32'hA3);
    repeat (2) step();
    chk("drained_qv", 0, 32'(q_valid[0]), 32'd0);

    // Full throughput, Depth 2 registered.
    for (int k = 0; k < 16; k++) begin
      d[1] = 8'(k); d_valid[1] = 1'b1;
      chk("tp_d_bp", 1, 32'(d_bp[1]), 32'd0);
      step();
      chk("tp_q", 1, 32'(q[1]), 32'(k));
      chk("tp_qv", 1, 32'(q_valid[1]), 32'd1);
    end
    d_valid[1] = 1'b0;
    step();
    chk("tp_count", 1, 32'(count[1]), 32'd0);

    // Fall-through.
    d[2] = 8'h5C; d_valid[2] = 1'b1;
    #1;
    chk("ft_q", 2, 32'(q[2]), 32'h5C);
    chk("ft_qv", 2, 32'(q_valid[2]), 32'd1);
    chk("ft_count", 2, 32'(count[2]), 32'd0);
    step();
    d_valid[2] = 1'b0;
    chk("ft_count_after", 2, 32'(count[2]), 32'd0);
    q_bp[2] = 1'b1; d_valid[2] = 1'b1;
    step();
    d_valid[2] = 1'b0;
    chk("ft_bp_count", 2, 32'(count[2]), 32'd1);
    chk("ft_bp_q", 2, 32'(q[2]), 32'h5C);
    q_bp[2] = 1'b0;
    step();
    chk("ft_emit_count", 2, 32'(count[2]), 32'd0);

    // Randomised traffic on all instances; u0 carries tokens 0..9.
    out0.delete();
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0; acc[i] = 1'b1; d_valid[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        q_bp[i] = ($urandom_range(0, 2) == 0);
        if (acc[i] || !d_valid[i]) begin
          if (i == 0 && seq[0] >= 10) d_valid[i] = 1'b0;
          else d_valid[i] = ($urandom_range(0, 3) != 0);
          d[i] = 8'(seq[i] + 64 * i);
        end
        acc[i] = d_valid[i] && !d_bp[i];
      end
      step();
      for (int i = 0; i < 3; i++) if (acc[i]) seq[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      d_valid[i] = 1'b0; q_bp[i] = 1'b0;
    end
    repeat (5) step();
    chk("order_len", 0, 32'(out0.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < out0.size()) chk("order", 0, 32'(out0[k]), 32'(k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
